// File: rtl/vcve2_vmem_seq.sv
// Vector load/store sequencer: moves one VRF register to or from memory as NW
// word transfers over an OBI-style port, with a bounded number of outstanding requests.
module vcve2_vmem_seq #(
    parameter int unsigned VLEN      = 128,
    parameter int unsigned MAX_OUTST = 2,
    localparam int unsigned NW = VLEN / 32,
    localparam int unsigned AW = 5 + $clog2(NW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          store_i,
    input  logic [31:0]   base_addr_i,
    input  logic [4:0]    vreg_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          vrf_data_req_o,
    input  logic          vrf_data_gnt_i,
    input  logic          vrf_data_rvalid_i,
    output logic          vrf_data_we_o,
    output logic [3:0]    vrf_data_be_o,
    output logic [31:0]   vrf_data_addr_o,
    output logic [31:0]   vrf_data_wdata_o,
    input  logic [31:0]   vrf_data_rdata_i,
    input  logic          vrf_data_err_i,
    output logic [AW-1:0] vrf_raddr_o,
    input  logic [31:0]   vrf_rdata_i,
    output logic          vrf_we_o,
    output logic [AW-1:0] vrf_waddr_o,
    output logic [31:0]   vrf_wdata_o
);
    localparam int unsigned LNW = $clog2(NW);
    localparam int unsigned CW  = $clog2(NW + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e        state_q, state_d;
    logic          store_q, store_d;
    logic [31:0]   base_q, base_d;
    logic [4:0]    vreg_q, vreg_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;

    logic          req;
    logic          gntFire;
    logic          rspFire;
    logic [31:0]   reqAddr;

    function automatic logic [AW-1:0] wordIdx(input logic [4:0] vreg, input logic [CW-1:0] cnt);
        return (AW'(vreg) << LNW) | AW'(cnt);
    endfunction

    // A request left ungranted stays asserted even if an error arrives meanwhile
    assign req = (state_q == ISSUE) &&
                 (pend_q || ((req_cnt_q < CW'(NW)) && (outst_q < OW'(MAX_OUTST)) && !err_q));
    assign gntFire = req && vrf_data_gnt_i;
    assign rspFire = vrf_data_rvalid_i && (outst_q != '0);
    assign reqAddr = base_q + (32'(req_cnt_q) << 2);

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        base_d    = base_q;
        vreg_d    = vreg_q;
        req_cnt_d = req_cnt_q + CW'(gntFire);
        rsp_cnt_d = rsp_cnt_q + CW'(rspFire);
        outst_d   = outst_q + OW'(gntFire) - OW'(rspFire);
        err_d     = err_q | (rspFire & vrf_data_err_i);
        pend_d    = req & ~vrf_data_gnt_i;
        done_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    store_d   = store_i;
                    base_d    = base_addr_i;
                    vreg_d    = vreg_i;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    outst_d   = '0;
                    pend_d    = 1'b0;
                    err_d     = (base_addr_i[1:0] != 2'b00);
                    state_d   = (base_addr_i[1:0] != 2'b00) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if ((req_cnt_q == CW'(NW)) || (err_q && !pend_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            store_q   <= 1'b0;
            base_q    <= '0;
            vreg_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            base_q    <= base_d;
            vreg_q    <= vreg_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    // The final response of a command can carry the error in the done cycle itself
    assign err_o  = done_o ? err_d : err_q;

    assign vrf_data_req_o   = req;
    assign vrf_data_we_o    = req & store_q;
    assign vrf_data_be_o    = req ? 4'hF : 4'h0;
    assign vrf_data_addr_o  = req ? reqAddr : 32'h0;
    assign vrf_raddr_o      = (req && store_q) ? wordIdx(vreg_q, req_cnt_q) : '0;
    assign vrf_data_wdata_o = (req && store_q) ? vrf_rdata_i : 32'h0;

    // Responses after an error are drained but never written back
    assign vrf_we_o    = rspFire & ~store_q & ~vrf_data_err_i & ~err_q;
    assign vrf_waddr_o = vrf_we_o ? wordIdx(vreg_q, rsp_cnt_q) : '0;
    assign vrf_wdata_o = vrf_we_o ? vrf_data_rdata_i : 32'h0;
endmodule
